core_mem_access_unit: RTL and testbench
=======================================

// Module: core_mem_access_unit
// PURPOSE
//  Data-memory bus master directly downstream of the execution unit's load/store address/data outputs.
//  Turns one combinational load/store request into a handshaked bus transaction (req/gnt, then rvalid).
//  Stalls the pipeline while the transaction is in flight; returns read data and error status for writeback.
//  Handles one outstanding transaction at a time; no pipelining of requests.
// PARAMETERS
//  ADDR_W          32   address width (= `MEM_ADDR_WIDTH)
//  DATA_W          32   data width (= `REG_DATA_WIDTH); byte-enable width is DATA_W/8
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk_i         in   1        clock, all state on rising edge
//  rst_i         in   1        synchronous active-high reset
//  req_valid_i   in   1        execution unit presents a load/store
//  req_we_i      in   1        1 = store, 0 = load
//  req_be_i      in   DATA_W/8 byte enables
//  req_addr_i    in   ADDR_W   address from execution unit
//  req_wdata_i   in   DATA_W   store data from execution unit
//  req_ready_o   out  1        1 only in IDLE
//  stall_o       out  1        freeze upstream pipeline
//  rsp_valid_o   out  1        one-cycle pulse: transaction complete
//  rsp_rdata_o   out  DATA_W   load data; 0 for stores/errors
//  rsp_err_o     out  1        bus error or timeout, valid with rsp_valid_o
//  bus_req_o     out  1        bus request
//  bus_we_o      out  1        bus write enable
//  bus_be_o      out  DATA_W/8 bus byte enables
//  bus_addr_o    out  ADDR_W   bus address
//  bus_wdata_o   out  DATA_W   bus write data
//  bus_gnt_i     in   1        bus accepted request
//  bus_rvalid_i  in   1        response valid (earliest: cycle after gnt)
//  bus_rdata_i   in   DATA_W   read data, sampled with rvalid
//  bus_err_i     in   1        error, sampled with rvalid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1; request registers cleared.
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE: on req_valid_i, latch we/be/addr/wdata; go to REQ.
//   REQ: bus_req_o=1, bus_* driven from latches and stable until gnt.
//        On bus_gnt_i go to WAIT; bus_req_o=0 from the next cycle.
//   WAIT: on bus_rvalid_i, capture rdata (loads only, else 0) and err; go to RESP.
//   RESP: rsp_valid_o=1 for exactly one cycle; return to IDLE.
//  stall_o = (IDLE & req_valid_i) | REQ | WAIT. stall_o=0 in RESP so writeback proceeds in that cycle.
//  Latency: accept at T; bus_req_o at T+1; gnt at T+1 -> earliest rvalid T+2 -> rsp_valid_o T+3.
//  Error: bus_err_i with rvalid -> rsp_err_o=1, rsp_rdata_o=0.
//  bus_rvalid_i in IDLE/REQ/RESP ignored; bus_gnt_i outside REQ ignored.
//  rsp_rdata_o/rsp_err_o hold their value until the next RESP.
//  req_valid_i during RESP is not accepted; it is taken in the following IDLE cycle.
//  rst_i mid-transaction: IDLE next edge, bus_req_o drops, pending response discarded.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: 8+ bit counter cleared on entering REQ, counts in REQ/WAIT.
//   At TIMEOUT_CYCLES: go to RESP with rsp_err_o=1, rdata=0.
//   Timeout in WAIT sets an orphan flag; the next bus_rvalid_i is swallowed, then the flag clears.
//   IDLE does not accept a new request while the orphan flag is set.
//  Not defined: no counter or orphan flag; a hung bus stalls indefinitely.
// STRUCTURE
//  src/defines.vh: FSM state encodings (MAU_IDLE..MAU_RESP, 2 bits) and `MEM_BE_WIDTH.
//  Sub-module core_mem_access_timeout: counter + expiry flag, instantiated only under MEM_TIMEOUT_EN.
// TESTING
//  Load, gnt at T+1, rvalid at T+2 with rdata=0xDEADBEEF
//   -> rsp_valid_o at T+3, rdata=0xDEADBEEF, stall_o high T..T+2.
//  Store addr=0x100 be=4'b0011 wdata=0x1234, gnt delayed 3 cycles
//   -> bus_* stable while waiting; rsp_valid_o with rdata=0.
//  Load with bus_err_i=1 at rvalid -> rsp_err_o=1, rsp_rdata_o=0.
//  rst_i asserted in WAIT -> IDLE next cycle, req_ready_o=1; later stray rvalid produces no rsp_valid_o.
//  Back-to-back loads, req_valid_i held through RESP -> second request latched the cycle after RESP.
//  MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never gnt -> rsp_err_o=1 after 4 cycles in REQ.
//   Same with late rvalid after a WAIT timeout -> rvalid swallowed.

Source files
------------

// File: rtl/core_mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit: FSM state encoding,
// default widths and the timeout counter width rule.
package core_mem_access_unit_pkg;

    localparam int unsigned MAU_ADDR_W = 32;
    localparam int unsigned MAU_DATA_W = 32;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_REQ  = 2'd1,
        MAU_WAIT = 2'd2,
        MAU_RESP = 2'd3
    } mau_state_e;

    // Timeout counter is never narrower than 8 bits.
    function automatic int unsigned mau_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/core_mem_access_timeout.sv
// Transaction timeout counter: cleared while idle, counts while enabled and
// saturates at the last cycle so the expiry flag stays up until it is serviced.
module core_mem_access_timeout
    import core_mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = mau_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;

    assign at_last   = (cnt_q >= LAST_CNT);
    assign expired_o = count_en_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !at_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_mem_access_unit.sv
// Load/store bus master: one outstanding req/gnt/rvalid transaction, stalls the
// pipeline while busy. Optional bus timeout and orphan-response swallowing under MEM_TIMEOUT_EN.
module core_mem_access_unit
    import core_mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W         = MAU_ADDR_W,
    parameter int unsigned DATA_W         = MAU_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                req_ready_o,
    output logic                stall_o,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_err_i,
    output logic [1:0]          dbg_state_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    mau_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                timeout_hit;
    logic                accept_block;
    logic                in_flight;

    assign in_flight = (state_q == MAU_REQ) || (state_q == MAU_WAIT);

`ifdef MEM_TIMEOUT_EN
    logic orphan_q, orphan_d;

    core_mem_access_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (!in_flight),
        .count_en_i (in_flight),
        .expired_o  (timeout_hit)
    );

    // A response still owed by the bus after a WAIT timeout must not be mistaken
    // for the reply to a later request, so new requests wait until it arrives.
    always_comb begin
        orphan_d = orphan_q;
        if (orphan_q && bus_rvalid_i) begin
            orphan_d = 1'b0;
        end
        if ((state_q == MAU_WAIT) && !bus_rvalid_i && timeout_hit) begin
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            orphan_q <= 1'b0;
        end else begin
            orphan_q <= orphan_d;
        end
    end

    assign accept_block = orphan_q;
`else
    logic cfg_unused;
    assign cfg_unused   = (TIMEOUT_CYCLES != 0);
    assign timeout_hit  = 1'b0;
    assign accept_block = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            MAU_IDLE: begin
                if (req_valid_i && !accept_block) begin
                    we_d    = req_we_i;
                    be_d    = req_be_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = MAU_REQ;
                end
            end
            MAU_REQ: begin
                // A grant in the expiry cycle still wins; the timeout then fires from WAIT.
                if (bus_gnt_i) begin
                    state_d = MAU_WAIT;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = MAU_RESP;
                end
            end
            MAU_WAIT: begin
                if (bus_rvalid_i) begin
                    rsp_rdata_d = (we_q || bus_err_i) ? '0 : bus_rdata_i;
                    rsp_err_d   = bus_err_i;
                    state_d     = MAU_RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = MAU_RESP;
                end
            end
            MAU_RESP: begin
                state_d = MAU_IDLE;
            end
            default: begin
                state_d = MAU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= MAU_IDLE;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = (state_q == MAU_IDLE) && !accept_block;
    assign stall_o     = ((state_q == MAU_IDLE) && req_valid_i) || in_flight;
    assign rsp_valid_o = (state_q == MAU_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign bus_req_o   = (state_q == MAU_REQ);
    assign bus_we_o    = we_q;
    assign bus_be_o    = be_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_core_mem_access_unit.sv
// Bench for core_mem_access_unit: cycle-exact directed bus transactions with a
// response scoreboard; timeout scenarios are exercised when MEM_TIMEOUT_EN is defined.
module tb_core_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_we_i = 1'b0;
    logic [3:0]    req_be_i = '0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          req_ready_o, stall_o, rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          bus_req_o, bus_we_o;
    logic [3:0]    bus_be_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic          bus_gnt_i = 1'b0;
    logic          bus_rvalid_i = 1'b0;
    logic [DW-1:0] bus_rdata_i = '0;
    logic          bus_err_i = 1'b0;
    logic [1:0]    dbg_state_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rsp_seen = 0;
    logic [DW:0] exp_q[$];

    core_mem_access_unit #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_be_i(req_be_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .stall_o(stall_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // scoreboard monitor: {err, rdata} per completed transaction
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o) begin
            logic [DW:0] e;
            rsp_seen++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got err=%0b rdata=0x%08h expected no response",
                         rsp_err_o, rsp_rdata_o);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err_o, rsp_rdata_o} === e) pass_cnt++;
                else $display("FAIL rsp_data: got err=%0b rdata=0x%08h expected err=%0b rdata=0x%08h",
                              rsp_err_o, rsp_rdata_o, e[DW], e[DW-1:0]);
            end
        end
    end

    // driver: full transaction with programmable grant / rvalid delays
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int gnt_dly, input int rv_dly,
                           input logic [DW-1:0] rdata, input logic err);
        logic [DW-1:0] exp_rd;
        exp_rd = (we || err) ? '0 : rdata;
        exp_q.push_back({err, exp_rd});
        req_valid_i = 1'b1; req_we_i = we; req_be_i = be; req_addr_i = addr; req_wdata_i = wdata;
        #1;
        chk("accept_stall", {31'd0, stall_o}, 32'd1);
        chk("accept_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0; req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("req_bus_req", {31'd0, bus_req_o}, 32'd1);
            chk("req_bus_addr", bus_addr_o, addr);
            chk("req_bus_ctl", {23'd0, bus_we_o, bus_be_o, 4'd0}, {23'd0, we, be, 4'd0});
            chk("req_bus_wdata", bus_wdata_o, wdata);
            chk("req_stall", {31'd0, stall_o}, 32'd1);
            if (i == gnt_dly) bus_gnt_i = 1'b1;
            tick();
        end
        bus_gnt_i = 1'b0;
        for (int i = 0; i <= rv_dly; i++) begin
            chk("wait_bus_req", {31'd0, bus_req_o}, 32'd0);
            chk("wait_stall", {31'd0, stall_o}, 32'd1);
            if (i == rv_dly) begin
                bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
            end
            tick();
        end
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h5555_5555; bus_err_i = 1'b0;
        chk("resp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("resp_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
        chk("idle_rdata_hold", rsp_rdata_o, exp_rd);
        chk("idle_err_hold", {31'd0, rsp_err_o}, {31'd0, err});
    endtask

    initial begin
        int seen;
        rst_i = 1'b1;
        tick(); tick();
        chk("rst_state", {30'd0, dbg_state_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_outs", {28'd0, stall_o, rsp_valid_o, rsp_err_o, bus_req_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_ctl", {27'd0, bus_we_o, bus_be_o}, 32'd0);

        // minimum-latency load
        run_txn(1'b0, 4'hF, 32'h0000_0040, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        // store with delayed grant: read data returned as zero
        run_txn(1'b1, 4'b0011, 32'h0000_0100, 32'h0000_1234, 3, 1, 32'hCAFE_F00D, 1'b0);
        // load with bus error: data forced to zero
        run_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 1, 0, 32'hFFFF_0000, 1'b1);
        run_txn(1'b0, 4'b1100, 32'h8000_0010, 32'h0, 1, 2, 32'hA5A5_5A5A, 1'b0);

        // reset while waiting for rvalid; later stray rvalid must be ignored
        req_valid_i = 1'b1; req_we_i = 1'b0; req_be_i = 4'hF; req_addr_i = 32'h300;
        tick();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("mid_rst_in_wait", {30'd0, dbg_state_o}, 32'd2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_idle", {30'd0, dbg_state_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("mid_rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        seen = rsp_seen;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
        tick();
        bus_rvalid_i = 1'b0;
        tick(); tick();
        chk("stray_rvalid_no_rsp", rsp_seen, seen);

        // back-to-back loads with req_valid held through RESP
        req_valid_i = 1'b1; req_we_i = 1'b0; req_be_i = 4'hF; req_addr_i = 32'h400;
        exp_q.push_back({1'b0, 32'h1111_1111});
        tick();
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        tick();
        bus_rvalid_i = 1'b0;
        chk("b2b_resp_state", {30'd0, dbg_state_o}, 32'd3);
        chk("b2b_resp_not_ready", {31'd0, req_ready_o}, 32'd0);
        req_addr_i = 32'h500;
        exp_q.push_back({1'b0, 32'h2222_2222});
        tick();
        chk("b2b_idle_state", {30'd0, dbg_state_o}, 32'd0);
        chk("b2b_idle_stall", {31'd0, stall_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("b2b_second_addr", bus_addr_o, 32'h500);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h2222_2222;
        tick();
        bus_rvalid_i = 1'b0;
        chk("b2b_second_resp", {31'd0, rsp_valid_o}, 32'd1);
        tick();

`ifdef MEM_TIMEOUT_EN
        // never granted: 4 cycles in REQ then error response
        exp_q.push_back({1'b1, 32'h0});
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h600;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_held", {31'd0, bus_req_o}, 32'd1);
            tick();
        end
        chk("to_req_resp", {31'd0, rsp_valid_o}, 32'd1);
        tick();

        // granted but no rvalid: timeout from WAIT, then late rvalid swallowed
        exp_q.push_back({1'b1, 32'h0});
        req_valid_i = 1'b1; req_addr_i = 32'h700;
        tick();
        req_valid_i = 1'b0; bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        tick(); tick();
        chk("to_wait_still", {30'd0, dbg_state_o}, 32'd2);
        tick();
        chk("to_wait_resp", {31'd0, rsp_valid_o}, 32'd1);
        tick();
        chk("orphan_not_ready", {31'd0, req_ready_o}, 32'd0);
        req_valid_i = 1'b1; req_addr_i = 32'h800;
        tick();
        chk("orphan_blocks_req", {30'd0, dbg_state_o}, 32'd0);
        req_valid_i = 1'b0;
        seen = rsp_seen;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h9999_9999;
        tick();
        bus_rvalid_i = 1'b0;
        tick();
        chk("orphan_swallowed", rsp_seen, seen);
        chk("orphan_cleared_ready", {31'd0, req_ready_o}, 32'd1);
        run_txn(1'b0, 4'hF, 32'h0000_0900, 32'h0, 0, 1, 32'h0BAD_CAFE, 1'b0);
`endif

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
